// File: rtl/fill_engine.sv
// Rectangle-fill engine: walks a clipped rectangle in raster order and issues one
// pixel write per covered on-screen pixel over the request/complete handshake.
module fill_engine #(
  parameter int SCREEN_WIDTH  = 320,
  parameter int SCREEN_HEIGHT = 240
) (
  input  logic       clock,
  input  logic       resetN,
  input  logic       cmdValid,
  output logic       cmdReady,
  input  logic [8:0] cmdX0,
  input  logic [7:0] cmdY0,
  input  logic [8:0] cmdWidth,
  input  logic [7:0] cmdHeight,
  input  logic [7:0] cmdColor,
  output logic [8:0] memoryXCoord,
  output logic [7:0] memoryYCoord,
  output logic [7:0] memoryWriteData,
  output logic       memoryWriteRequest,
  input  logic       memoryWriteComplete,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {IDLE, SETUP, REQUEST, GAP, DONE} state_t;

  localparam logic [9:0] X_LIMIT = 10'(SCREEN_WIDTH);
  localparam logic [9:0] Y_LIMIT = 10'(SCREEN_HEIGHT);

  state_t     state, state_next;
  logic [8:0] x0, width, cur_x;
  logic [7:0] y0, height, cur_y, color;
  logic [9:0] x_end, y_end;
  logic [9:0] x_sum, y_sum, x_end_calc, y_end_calc;
  logic       empty, x_step, y_step;

  // Extents are evaluated in 10 bits so that x0+width can never wrap.
  always_comb begin
    x_sum      = {1'b0, x0} + {1'b0, width};
    y_sum      = {2'b0, y0} + {2'b0, height};
    x_end_calc = (x_sum > X_LIMIT) ? X_LIMIT : x_sum;
    y_end_calc = (y_sum > Y_LIMIT) ? Y_LIMIT : y_sum;
    empty      = (width == 9'd0) || (height == 8'd0) ||
                 ({1'b0, x0} >= X_LIMIT) || ({2'b0, y0} >= Y_LIMIT);
    x_step     = ({1'b0, cur_x} + 10'd1) < x_end;
    y_step     = ({2'b0, cur_y} + 10'd1) < y_end;
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cmdValid) state_next = SETUP;
      SETUP:   state_next = empty ? DONE : REQUEST;
      REQUEST: if (memoryWriteComplete) state_next = (x_step || y_step) ? GAP : DONE;
      GAP:     state_next = REQUEST;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      x0     <= '0;
      y0     <= '0;
      width  <= '0;
      height <= '0;
      color  <= '0;
      x_end  <= '0;
      y_end  <= '0;
      cur_x  <= '0;
      cur_y  <= '0;
    end else begin
      case (state)
        IDLE: if (cmdValid) begin
          x0     <= cmdX0;
          y0     <= cmdY0;
          width  <= cmdWidth;
          height <= cmdHeight;
          color  <= cmdColor;
        end
        SETUP: begin
          x_end <= x_end_calc;
          y_end <= y_end_calc;
          if (!empty) begin
            cur_x <= x0;
            cur_y <= y0;
          end
        end
        REQUEST: if (memoryWriteComplete) begin
          if (x_step) begin
            cur_x <= cur_x + 9'd1;
          end else if (y_step) begin
            cur_x <= x0;
            cur_y <= cur_y + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign cmdReady           = (state == IDLE);
  assign busy               = (state != IDLE);
  assign done               = (state == DONE);
  assign memoryWriteRequest = (state == REQUEST);
  assign memoryXCoord       = cur_x;
  assign memoryYCoord       = cur_y;
  assign memoryWriteData    = color;

endmodule

// File: tb/tb_fill_engine.sv
// Bench for fill_engine: a memory responder/monitor plus a raster reference model
// built from plain nested loops over the clipped rectangle.
module tb_fill_engine;

  logic       clock = 1'b0;
  logic       resetN = 1'b0;
  logic       cmdValid = 1'b0;
  logic       cmdReady;
  logic [8:0] cmdX0 = '0;
  logic [7:0] cmdY0 = '0;
  logic [8:0] cmdWidth = '0;
  logic [7:0] cmdHeight = '0;
  logic [7:0] cmdColor = '0;
  logic [8:0] memoryXCoord;
  logic [7:0] memoryYCoord;
  logic [7:0] memoryWriteData;
  logic       memoryWriteRequest;
  logic       memoryWriteComplete = 1'b0;
  logic       busy;
  logic       done;

  fill_engine #(.SCREEN_WIDTH(320), .SCREEN_HEIGHT(240)) dut (
    .clock(clock), .resetN(resetN),
    .cmdValid(cmdValid), .cmdReady(cmdReady),
    .cmdX0(cmdX0), .cmdY0(cmdY0), .cmdWidth(cmdWidth), .cmdHeight(cmdHeight),
    .cmdColor(cmdColor),
    .memoryXCoord(memoryXCoord), .memoryYCoord(memoryYCoord),
    .memoryWriteData(memoryWriteData), .memoryWriteRequest(memoryWriteRequest),
    .memoryWriteComplete(memoryWriteComplete),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {int x; int y; int d; int c;} wr_t;

  wr_t  wr_q[$];
  wr_t  exp_q[$];
  int   done_q[$];
  int   gap_q[$];
  int   busy_cnt = 0;
  int   stab_err = 0;
  int   low_run = 0;
  int   ack_cnt = 0;
  int   lat = 0;
  bit   auto_ack = 1'b1;
  bit   prev_req = 1'b0;
  bit   prev_ack = 1'b0;
  bit   seen_write = 1'b0;
  logic [8:0] px;
  logic [7:0] py, pd;

  int n_cmp = 0;
  int n_err = 0;

  // Monitor and memory responder share one negedge process so ordering is fixed.
  initial begin
    forever begin
      @(negedge clock);
      if (busy) busy_cnt++;
      if (done) done_q.push_back(cyc);
      if (memoryWriteRequest) begin
        if (prev_req && !prev_ack &&
            (memoryXCoord !== px || memoryYCoord !== py || memoryWriteData !== pd))
          stab_err++;
        if (!prev_req && seen_write) gap_q.push_back(low_run);
        low_run = 0;
      end else if (busy) begin
        low_run++;
      end
      prev_req = memoryWriteRequest;
      px = memoryXCoord;
      py = memoryYCoord;
      pd = memoryWriteData;
      if (auto_ack) begin
        if (memoryWriteRequest && !memoryWriteComplete) begin
          if (ack_cnt >= lat) begin
            memoryWriteComplete = 1'b1;
            wr_q.push_back('{int'(memoryXCoord), int'(memoryYCoord), int'(memoryWriteData), cyc});
            seen_write = 1'b1;
            ack_cnt = 0;
          end else begin
            ack_cnt++;
          end
        end else begin
          memoryWriteComplete = 1'b0;
          ack_cnt = 0;
        end
      end
      prev_ack = memoryWriteComplete;
    end
  end

  task automatic clear_logs();
    wr_q.delete();
    done_q.delete();
    gap_q.delete();
    busy_cnt = 0;
    stab_err = 0;
    low_run = 0;
    seen_write = 1'b0;
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  // Reference: every on-screen pixel of the rectangle, x inner loop, y outer loop.
  task automatic build_expected(input int x0, input int y0, input int w, input int h, input int c);
    exp_q.delete();
    for (int y = y0; y < y0 + h; y++)
      for (int x = x0; x < x0 + w; x++)
        if (x < 320 && y < 240) exp_q.push_back('{x, y, c, 0});
  endtask

  task automatic run_cmd(input int x0, input int y0, input int w, input int h, input int c,
                         input int l, input bit hold, input string name);
    int acc, t, bad;
    lat = l;
    clear_logs();
    build_expected(x0, y0, w, h, c);
    cmdX0 = 9'(x0); cmdY0 = 8'(y0); cmdWidth = 9'(w); cmdHeight = 8'(h); cmdColor = 8'(c);
    cmdValid = 1'b1;
    acc = cyc + 1;
    step();
    if (!hold) cmdValid = 1'b0;
    cmdX0 = 9'($urandom); cmdY0 = 8'($urandom); cmdWidth = 9'($urandom);
    cmdHeight = 8'($urandom); cmdColor = 8'($urandom);
    t = 0;
    while (done_q.size() == 0 && t < 3000) begin
      step();
      t++;
    end
    cmdValid = 1'b0;
    n_cmp++;
    if (done_q.size() == 0) begin
      n_err++;
      $display("FAIL %s timeout: no done after %0d cycles (want done)", name, t);
      return;
    end
    step();
    n_cmp++;
    if (cmdReady !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s ready_after_done: cmdReady=%b busy=%b want 1/0", name, cmdReady, busy);
    end
    repeat (3) step();
    n_cmp++;
    if (done_q.size() != 1) begin
      n_err++;
      $display("FAIL %s done_count: got %0d want 1", name, done_q.size());
    end
    n_cmp++;
    bad = (wr_q.size() != exp_q.size()) ? 1 : 0;
    for (int i = 0; i < wr_q.size() && i < exp_q.size() && bad == 0; i++)
      if (wr_q[i].x != exp_q[i].x || wr_q[i].y != exp_q[i].y || wr_q[i].d != exp_q[i].d) begin
        bad = 1;
        $display("FAIL %s write[%0d]: got (%0d,%0d,%0h) want (%0d,%0d,%0h)", name, i,
                 wr_q[i].x, wr_q[i].y, wr_q[i].d, exp_q[i].x, exp_q[i].y, exp_q[i].d);
      end
    if (bad != 0) begin
      n_err++;
      $display("FAIL %s writes: got %0d writes want %0d", name, wr_q.size(), exp_q.size());
    end
    n_cmp++;
    if (exp_q.size() == 0) begin
      if (done_q[0] != acc + 1) begin
        n_err++;
        $display("FAIL %s empty_done_time: got T+%0d want T+2", name, done_q[0] - acc + 1);
      end
    end else if (wr_q.size() > 0) begin
      if (done_q[0] != wr_q[wr_q.size()-1].c + 1 || wr_q[0].c != acc + 1 + l) begin
        n_err++;
        $display("FAIL %s timing: first_ack=%0d done=%0d want first_ack=%0d done=last_ack+1=%0d",
                 name, wr_q[0].c - acc, done_q[0], 1 + l, wr_q[wr_q.size()-1].c + 1);
      end
    end
    n_cmp++;
    if (busy_cnt != done_q[0] - acc + 1) begin
      n_err++;
      $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_cnt, done_q[0] - acc + 1);
    end
    n_cmp++;
    bad = 0;
    foreach (gap_q[i]) if (gap_q[i] != 1) bad = 1;
    if (bad != 0 || stab_err != 0 ||
        (exp_q.size() > 0 && gap_q.size() != exp_q.size() - 1)) begin
      n_err++;
      $display("FAIL %s gaps/stability: gaps=%0d stab_err=%0d want %0d one-cycle gaps, 0 errs",
               name, gap_q.size(), stab_err, (exp_q.size() > 0) ? exp_q.size() - 1 : 0);
    end
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    repeat (3) step();
    n_cmp++;
    if (cmdReady !== 1'b1 || memoryWriteRequest !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        memoryXCoord !== 9'd0 || memoryYCoord !== 8'd0 || memoryWriteData !== 8'd0) begin
      n_err++;
      $display("FAIL reset_values: rdy=%b req=%b busy=%b done=%b x=%0d y=%0d d=%0h want 1,0,0,0,0,0,0",
               cmdReady, memoryWriteRequest, busy, done, memoryXCoord, memoryYCoord, memoryWriteData);
    end
    resetN = 1'b1;
    step();
  endtask

  task automatic test_single();
    run_cmd(10, 20, 1, 1, 8'hAB, 2, 1'b0, "single");
  endtask

  task automatic test_fill_3x2();
    run_cmd(0, 0, 3, 2, 8'h55, 0, 1'b0, "fill3x2");
  endtask

  task automatic test_clip();
    run_cmd(318, 239, 5, 5, 8'h0F, 1, 1'b0, "clip_corner");
    run_cmd(320, 0, 4, 4, 8'h11, 0, 1'b0, "clip_offscreen");
  endtask

  task automatic test_zero();
    run_cmd(30, 40, 0, 3, 8'h22, 0, 1'b0, "zero_width");
    run_cmd(30, 40, 3, 0, 8'h33, 0, 1'b0, "zero_height");
  endtask

  task automatic test_stall();
    run_cmd(100, 100, 2, 1, 8'h77, 5, 1'b1, "stall_hold_valid");
  endtask

  task automatic test_spurious();
    int t;
    auto_ack = 1'b0;
    clear_logs();
    memoryWriteComplete = 1'b1;
    step();
    step();
    memoryWriteComplete = 1'b0;
    n_cmp++;
    if (memoryWriteRequest !== 1'b0 || busy !== 1'b0 || done_q.size() != 0) begin
      n_err++;
      $display("FAIL spurious_idle: req=%b busy=%b dones=%0d want 0,0,0",
               memoryWriteRequest, busy, done_q.size());
    end
    cmdX0 = 9'd40; cmdY0 = 8'd7; cmdWidth = 9'd2; cmdHeight = 8'd1; cmdColor = 8'h3C;
    cmdValid = 1'b1;
    step();
    cmdValid = 1'b0;
    t = 0;
    while (memoryWriteRequest !== 1'b1 && t < 20) begin step(); t++; end
    repeat (5) step();
    n_cmp++;
    if (memoryWriteRequest !== 1'b1 || memoryXCoord !== 9'd40 || memoryYCoord !== 8'd7 ||
        memoryWriteData !== 8'h3C) begin
      n_err++;
      $display("FAIL spurious_first_req: req=%b x=%0d y=%0d d=%0h want 1,40,7,3c",
               memoryWriteRequest, memoryXCoord, memoryYCoord, memoryWriteData);
    end
    memoryWriteComplete = 1'b1;
    step();
    n_cmp++;
    if (memoryWriteRequest !== 1'b0) begin
      n_err++;
      $display("FAIL spurious_gap_low: req=%b want 0", memoryWriteRequest);
    end
    step();
    memoryWriteComplete = 1'b0;
    n_cmp++;
    if (memoryWriteRequest !== 1'b1 || memoryXCoord !== 9'd41 || done_q.size() != 0) begin
      n_err++;
      $display("FAIL spurious_gap_ignored: req=%b x=%0d dones=%0d want 1,41,0",
               memoryWriteRequest, memoryXCoord, done_q.size());
    end
    memoryWriteComplete = 1'b1;
    step();
    memoryWriteComplete = 1'b0;
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL spurious_done: done=%b want 1", done);
    end
    step();
    auto_ack = 1'b1;
    step();
  endtask

  task automatic test_reset_mid();
    int t;
    lat = 3;
    clear_logs();
    cmdX0 = 9'd100; cmdY0 = 8'd50; cmdWidth = 9'd4; cmdHeight = 8'd4; cmdColor = 8'h9E;
    cmdValid = 1'b1;
    step();
    cmdValid = 1'b0;
    t = 0;
    while (wr_q.size() < 3 && t < 200) begin step(); t++; end
    t = 0;
    step();
    while (memoryWriteRequest !== 1'b1 && t < 20) begin step(); t++; end
    resetN = 1'b0;
    #1;
    n_cmp++;
    if (wr_q.size() != 3 || memoryWriteRequest !== 1'b0 || busy !== 1'b0 || cmdReady !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_drop: writes=%0d req=%b busy=%b rdy=%b want 3,0,0,1",
               wr_q.size(), memoryWriteRequest, busy, cmdReady);
    end
    repeat (3) step();
    resetN = 1'b1;
    repeat (2) step();
    n_cmp++;
    if (done_q.size() != 0) begin
      n_err++;
      $display("FAIL reset_mid_no_done: got %0d done pulses want 0", done_q.size());
    end
    run_cmd(5, 5, 1, 1, 8'hC3, 1, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    int x0, y0, w, h;
    for (int i = 0; i < 14; i++) begin
      x0 = ($urandom_range(0, 2) == 0) ? $urandom_range(310, 325) : $urandom_range(0, 300);
      y0 = ($urandom_range(0, 2) == 0) ? $urandom_range(232, 245) : $urandom_range(0, 230);
      w  = $urandom_range(0, 6);
      h  = $urandom_range(0, 5);
      run_cmd(x0, y0, w, h, $urandom_range(0, 255), $urandom_range(0, 4),
              1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_3x2();
    test_clip();
    test_zero();
    test_stall();
    test_spurious();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
